// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared encodings for the stream reducer family: operation
//               codes, control-state encoding and an elaboration-time width
//               guard macro.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef STREAM_PKG_MACROS_SV
`define STREAM_PKG_MACROS_SV
// Elaboration-time guard: stops the build when A < B. Use inside a module
// body; LBL names the generate block so the check is visible in hierarchy.
`define STREAM_CHECK_GE(LBL, A, B) \
    if ((A) < (B)) begin : LBL \
        $error("stream_pkg: width check failed"); \
    end
`endif

package stream_pkg;

    // Fold operation encodings
    localparam logic [1:0] OP_SUM = 2'd0;
    localparam logic [1:0] OP_MIN = 2'd1;
    localparam logic [1:0] OP_MAX = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    // Frame control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_reduce_alu.sv
`default_nettype none
// ============================================================================
// Module      : stream_reduce_alu
// Description : Combinational fold step f(a, ext) for sum/min/max/xor.
//               Optional macro STREAM_REDUCE_SAT_EN turns the sum into a
//               saturating add and exposes a per-step clamp flag.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_reduce_alu
    import stream_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic [1:0]       op,
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] ext,
    output logic [ACC_W-1:0] result
`ifdef STREAM_REDUCE_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam logic c_signed = (SIGNED != 0);

    logic [ACC_W-1:0] w_sum;
    logic             w_lt;
    logic             w_gt;

`ifdef STREAM_REDUCE_SAT_EN
    // Carry-out kept for unsigned clamp detection
    logic [ACC_W:0]   w_wide;
    logic             w_ovf;
    assign w_wide = {1'b0, a} + {1'b0, ext};
    assign w_sum  = w_wide[ACC_W-1:0];
    // Signed overflow: operands agree in sign but the result does not
    assign w_ovf  = (a[ACC_W-1] == ext[ACC_W-1]) && (w_sum[ACC_W-1] != a[ACC_W-1]);
`else
    assign w_sum  = a + ext;
`endif

    assign w_lt = c_signed ? ($signed(ext) < $signed(a)) : (ext < a);
    assign w_gt = c_signed ? ($signed(ext) > $signed(a)) : (ext > a);

    // Select the fold result for the requested operation
    always_comb begin
        result = a;
`ifdef STREAM_REDUCE_SAT_EN
        sat    = 1'b0;
`endif
        case (op)
            OP_SUM: begin
                result = w_sum;
`ifdef STREAM_REDUCE_SAT_EN
                if (c_signed) begin
                    if (w_ovf) begin
                        result = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                            : {1'b0, {(ACC_W-1){1'b1}}};
                        sat    = 1'b1;
                    end
                end else if (w_wide[ACC_W]) begin
                    result = {ACC_W{1'b1}};
                    sat    = 1'b1;
                end
`endif
            end
            OP_MIN:  result = w_lt ? ext : a;
            OP_MAX:  result = w_gt ? ext : a;
            OP_XOR:  result = a ^ ext;
            default: result = a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/stream_reduce.sv
`default_nettype none
// ============================================================================
// Module      : stream_reduce
// Description : Back-pressured stream reducer. Folds each in_last-terminated
//               frame into one scalar (sum/min/max/xor) seeded by init_in and
//               reports the beat count. Optional macro STREAM_REDUCE_SAT_EN
//               enables saturating sum and the out_sat flag.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_reduce
    import stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [1:0]        op,
    input  logic [ACC_W-1:0]  init_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count
`ifdef STREAM_REDUCE_SAT_EN
    ,
    output logic              out_sat
`endif
);

    localparam logic c_signed = (SIGNED != 0);

    `STREAM_CHECK_GE(g_acc_w_check, ACC_W, DATA_W)

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_alu_a;
    logic [1:0]       w_alu_op;
    logic [ACC_W-1:0] w_alu_res;
    logic             w_accept;
    logic             w_first;

    // Widen the element to accumulator width
    generate
        if (ACC_W > DATA_W) begin : g_ext_pad
            assign w_ext = {{(ACC_W-DATA_W){c_signed & in_data[DATA_W-1]}}, in_data};
        end else begin : g_ext_same
            assign w_ext = in_data;
        end
    endgenerate

    // The first beat of a frame folds against the seed using the live op;
    // later beats use the op captured at frame start.
    assign w_first  = (r_state == IDLE);
    assign w_alu_a  = w_first ? init_in : r_acc;
    assign w_alu_op = w_first ? op      : r_op;
    assign w_accept = in_valid && r_in_ready;

`ifdef STREAM_REDUCE_SAT_EN
    logic w_alu_sat;
    logic r_sat;
`endif

    stream_reduce_alu #(
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
    ) u_alu (
        .op     (w_alu_op),
        .a      (w_alu_a),
        .ext    (w_ext),
        .result (w_alu_res)
`ifdef STREAM_REDUCE_SAT_EN
        ,
        .sat    (w_alu_sat)
`endif
    );

    // Frame control, accumulator and registered handshake outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_op        <= OP_SUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef STREAM_REDUCE_SAT_EN
            r_sat       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_alu_res;
                        if (w_first) begin
                            r_op  <= op;
                            r_cnt <= CNT_W'(1);
`ifdef STREAM_REDUCE_SAT_EN
                            r_sat <= w_alu_sat;
`endif
                        end else begin
                            if (r_cnt != {CNT_W{1'b1}}) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
`ifdef STREAM_REDUCE_SAT_EN
                            r_sat <= r_sat | w_alu_sat;
`endif
                        end
                        if (in_last) begin
                            r_state     <= EMIT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= ACCUM;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign out_count = r_cnt;
`ifdef STREAM_REDUCE_SAT_EN
    assign out_sat   = r_sat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_reduce
// Description : Self-checking bench for stream_reduce. Three instances share
//               one control stream: 32-bit signed, 32-bit unsigned and 8-bit
//               signed. A frame-level model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_reduce;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [1:0]  op = 2'd0;
    logic [31:0] init_s = '0;
    logic [31:0] init_u = '0;
    logic [7:0]  init_8 = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        rdy_s, rdy_u, rdy_8;
    logic        ov_s, ov_u, ov_8;
    logic [31:0] od_s, od_u;
    logic [7:0]  od_8;
    logic [15:0] oc_s, oc_u, oc_8;
`ifdef STREAM_REDUCE_SAT_EN
    logic        os_s, os_u, os_8;
`endif

    always #5 clk = ~clk;

    stream_reduce #(.DATA_W(32), .ACC_W(32), .CNT_W(16), .SIGNED(1)) u_s (
        .clk(clk), .nrst(nrst), .op(op), .init_in(init_s),
        .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data), .in_last(in_last),
        .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s), .out_count(oc_s)
`ifdef STREAM_REDUCE_SAT_EN
        , .out_sat(os_s)
`endif
    );

    stream_reduce #(.DATA_W(32), .ACC_W(32), .CNT_W(16), .SIGNED(0)) u_u (
        .clk(clk), .nrst(nrst), .op(op), .init_in(init_u),
        .in_valid(in_valid), .in_ready(rdy_u), .in_data(in_data), .in_last(in_last),
        .out_valid(ov_u), .out_ready(out_ready), .out_data(od_u), .out_count(oc_u)
`ifdef STREAM_REDUCE_SAT_EN
        , .out_sat(os_u)
`endif
    );

    stream_reduce #(.DATA_W(8), .ACC_W(8), .CNT_W(16), .SIGNED(1)) u_8 (
        .clk(clk), .nrst(nrst), .op(op), .init_in(init_8),
        .in_valid(in_valid), .in_ready(rdy_8), .in_data(in_data[7:0]), .in_last(in_last),
        .out_valid(ov_8), .out_ready(out_ready), .out_data(od_8), .out_count(oc_8)
`ifdef STREAM_REDUCE_SAT_EN
        , .out_sat(os_8)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [31:0] beats[$];
    bit          m_emit = 1'b0;
    logic [1:0]  m_op;
    logic [31:0] m_init_s, m_init_u;
    logic [7:0]  m_init_8;
    logic [63:0] e_s, e_u, e_8;
    bit          e_sat_s, e_sat_u, e_sat_8;
    int          e_cnt;

    function automatic longint extend(input logic [63:0] v, input int w, input bit sgn);
        logic [63:0] mk;
        logic [63:0] m;
        mk = (64'd1 << w) - 64'd1;
        m  = v & mk;
        if (sgn && m[w-1]) m = m | ~mk;
        return longint'(m);
    endfunction

    function automatic logic [63:0] fold(input logic [1:0] f_op, input logic [63:0] f_init,
                                         input int aw, input int dw, input bit sgn,
                                         output bit sat);
        longint a, x, lo, hi;
        sat = 1'b0;
        lo  = sgn ? -(longint'(1) << (aw - 1)) : 0;
        hi  = sgn ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
        a   = extend(f_init, aw, sgn);
        foreach (beats[i]) begin
            x = extend({32'd0, beats[i]}, dw, sgn);
            case (f_op)
                2'd0: begin
                    a = a + x;
`ifdef STREAM_REDUCE_SAT_EN
                    if (a > hi) begin a = hi; sat = 1'b1; end
                    else if (a < lo) begin a = lo; sat = 1'b1; end
`endif
                end
                2'd1:    if (x < a) a = x;
                2'd2:    if (x > a) a = x;
                default: a = a ^ x;
            endcase
        end
        return 64'(a) & ((64'd1 << aw) - 64'd1);
    endfunction

    // Track accepted beats; produce the expected result when a frame closes
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_emit = 1'b0;
            beats.delete();
        end else if (m_emit) begin
            if (out_ready) m_emit = 1'b0;
        end else if (in_valid) begin
            if (beats.size() == 0) begin
                m_op     = op;
                m_init_s = init_s;
                m_init_u = init_u;
                m_init_8 = init_8;
            end
            beats.push_back(in_data);
            if (in_last) begin
                e_s   = fold(m_op, {32'd0, m_init_s}, 32, 32, 1'b1, e_sat_s);
                e_u   = fold(m_op, {32'd0, m_init_u}, 32, 32, 1'b0, e_sat_u);
                e_8   = fold(m_op, {56'd0, m_init_8}, 8, 8, 1'b1, e_sat_8);
                e_cnt = (beats.size() > 65535) ? 65535 : beats.size();
                beats.delete();
                m_emit = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("in_ready_s", rdy_s, !m_emit);
        check("in_ready_u", rdy_u, !m_emit);
        check("in_ready_8", rdy_8, !m_emit);
        check("out_valid_s", ov_s, m_emit);
        check("out_valid_u", ov_u, m_emit);
        check("out_valid_8", ov_8, m_emit);
        if (m_emit) begin
            check("out_data_s", od_s, e_s);
            check("out_data_u", od_u, e_u);
            check("out_data_8", od_8, e_8);
            check("out_count_s", oc_s, e_cnt);
            check("out_count_u", oc_u, e_cnt);
            check("out_count_8", oc_8, e_cnt);
`ifdef STREAM_REDUCE_SAT_EN
            check("out_sat_s", os_s, e_sat_s);
            check("out_sat_u", os_u, e_sat_u);
            check("out_sat_8", os_8, e_sat_8);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic frame_set(input logic [1:0] o, input logic [31:0] is,
                             input logic [31:0] iu, input logic [7:0] i8);
        op = o; init_s = is; init_u = iu; init_8 = i8;
    endtask

    task automatic send(input logic [31:0] d, input bit last);
        int guard = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!rdy_s && guard < 50) begin step(); guard++; end
        if (!rdy_s) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
        end
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic collect(input int hold, input logic [31:0] xs, input logic [31:0] xu,
                           input logic [7:0] x8, input logic [15:0] xc);
        int guard = 0;
        while (!ov_s && guard < 50) begin step(); guard++; end
        check("latency", guard, 0);
        repeat (hold) begin
            check("hold_data", od_s, xs);
            check("hold_count", oc_s, xc);
            check("hold_in_ready", rdy_s, 1'b0);
            step();
        end
        check("lit_data_s", od_s, xs);
        check("lit_data_u", od_u, xu);
        check("lit_data_8", od_8, x8);
        check("lit_count", oc_s, xc);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_drop", ov_s, 1'b0);
    endtask

    initial begin
        #1 nrst = 1'b0;
        #1;
        check("rst_out_valid", ov_s, 1'b0);
        check("rst_in_ready", rdy_s, 1'b1);
        check("rst_out_data", od_s, 32'd0);
        check("rst_out_count", oc_s, 16'd0);
        repeat (2) step();
        nrst = 1'b1;
        step();

        // Sum 1..4
        frame_set(2'd0, 32'd0, 32'd0, 8'd0);
        send(32'd1, 0); send(32'd2, 0); send(32'd3, 0); send(32'd4, 1);
        collect(0, 32'd10, 32'd10, 8'd10, 16'd4);

        // Min with signed/unsigned seeds
        frame_set(2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 8'h7F);
        send(32'd5, 0); send(32'hFFFF_FFFD, 0); send(32'd7, 1);
        collect(0, 32'hFFFF_FFFD, 32'd5, 8'hFD, 16'd3);

        // Xor under 5 cycles of back-pressure
        frame_set(2'd3, 32'd0, 32'd0, 8'd0);
        send(32'hF0, 0); send(32'h0F, 1);
        collect(5, 32'hFF, 32'hFF, 8'hFF, 16'd2);

        // Single-beat max frame
        frame_set(2'd2, 32'd100, 32'd100, 8'd100);
        send(32'd42, 1);
        collect(0, 32'd100, 32'd100, 8'd100, 16'd1);

        // Max with gaps; op/seed changes mid-frame must be ignored
        frame_set(2'd2, 32'd0, 32'd0, 8'd0);
        send(32'd3, 0);
        frame_set(2'd0, 32'd1000, 32'd1000, 8'h55);
        repeat (3) step();
        send(32'd9, 0);
        repeat (2) step();
        send(32'd4, 1);
        collect(0, 32'd9, 32'd9, 8'd9, 16'd3);

        // Reset in mid-frame
        frame_set(2'd0, 32'd0, 32'd0, 8'd0);
        send(32'd1, 0); send(32'd1, 0);
        nrst = 1'b0;
        #1;
        check("midrst_out_valid", ov_s, 1'b0);
        check("midrst_in_ready", rdy_s, 1'b1);
        check("midrst_out_count", oc_s, 16'd0);
        check("midrst_out_data", od_s, 32'd0);
        @(posedge clk); #2;
        step();
        nrst = 1'b1;
        step();

        // Fresh frame after reset
        send(32'd7, 0); send(32'd8, 1);
        collect(0, 32'd15, 32'd15, 8'd15, 16'd2);

        // 8-bit sum overflow
        frame_set(2'd0, 32'd0, 32'd0, 8'd0);
        send(32'd100, 0); send(32'd100, 1);
`ifdef STREAM_REDUCE_SAT_EN
        while (!ov_s) step();
        check("sat_flag_8", os_8, 1'b1);
        collect(0, 32'd200, 32'd200, 8'h7F, 16'd2);
`else
        collect(0, 32'd200, 32'd200, 8'hC8, 16'd2);
`endif

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
